// File: rtl/rambus_pkg.sv
// Shared definitions for the APB-to-RamBus bridge: default widths, the
// error read-back word and the bridge state encoding.
package rambus_pkg;

  localparam int unsigned RB_ADDR_W      = 14;
  localparam int unsigned RB_DATA_W      = 32;
  localparam int unsigned RB_TIMEOUT_CYC = 256;

  localparam logic [RB_ADDR_W-1:0] RB_ADDR_LIMIT = 14'h3FFF;
  localparam logic [RB_DATA_W-1:0] RB_ERR_DATA   = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUS_SETUP = 2'd1,
    ST_LATCH     = 2'd2,
    ST_DONE      = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/rambus_timeout_ctr.sv
// Access watchdog for the bridge: counts cycles while enabled and flags the
// last cycle of a TERMINAL-cycle window. Clear has priority over enable.
module rambus_timeout_ctr #(
  parameter int unsigned TERMINAL = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned      CNT_W = $clog2(TERMINAL + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TERMINAL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, advance (saturating at the terminal value) or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The enabled cycle holding LAST is the TERMINAL-th counted cycle.
  assign tc_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/apb_rambus_bridge.sv
// APB3 slave to RamBus master bridge. Each APB transfer is registered in the
// setup phase, replayed on RamBus as nCs/WrnRd/Latch until Ack, and completed
// with a single-cycle PREADY. Out-of-range addresses complete immediately with
// PSLVERR and never touch RamBus.
// Build option: define RAMBUS_BRIDGE_TIMEOUT_EN to abort accesses that see no
// Ack within TIMEOUT_CYC cycles of LATCH (reported on PSLVERR).
module apb_rambus_bridge
  import rambus_pkg::*;
#(
  parameter int unsigned        ADDR_W      = RB_ADDR_W,
  parameter int unsigned        DATA_W      = RB_DATA_W,
  parameter logic [ADDR_W-1:0]  ADDR_LIMIT  = RB_ADDR_LIMIT,
  parameter int unsigned        TIMEOUT_CYC = RB_TIMEOUT_CYC,
  parameter logic [DATA_W-1:0]  ERR_DATA    = RB_ERR_DATA
) (
  input  logic              clk,
  input  logic              rst_n,
  // APB3 slave
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  // RamBus master
  output logic [ADDR_W-1:0] RamBusAddress,
  output logic [DATA_W-1:0] RamBusDataIn,
  output logic              RamBusnCs,
  output logic              RamBusWrnRd,
  output logic              RamBusLatch,
  input  logic [DATA_W-1:0] RamBusDataOut,
  input  logic              RamBusAck
);

  // The watchdog needs at least one cycle of LATCH to count.
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be non-zero");
  end

  bridge_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wrnrd_q, wrnrd_d;
  logic              ncs_q, ncs_d;
  logic              latch_q, latch_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              err_q, err_d;
  logic              timeout_tc;

`ifdef RAMBUS_BRIDGE_TIMEOUT_EN
  // Cleared during BUS_SETUP so the count starts at zero on LATCH entry.
  rambus_timeout_ctr #(
    .TERMINAL (TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q == ST_BUS_SETUP),
    .en_i    (state_q == ST_LATCH),
    .tc_o    (timeout_tc)
  );
`else
  assign timeout_tc = 1'b0;
`endif

  // Next-state and next-register logic for the transfer sequencer.
  always_comb begin
    // NOTE: every signal gets a hold/default value before the case so no
    // path through this block leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wrnrd_d  = wrnrd_q;
    ncs_d    = ncs_q;
    latch_d  = latch_q;
    prdata_d = prdata_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          wdata_d = PWDATA;
          wrnrd_d = PWRITE;
          if (PADDR <= ADDR_LIMIT) begin
            ncs_d   = 1'b1;
            state_d = ST_BUS_SETUP;
          end else begin
            err_d = 1'b1;
            if (!PWRITE) prdata_d = ERR_DATA;
            state_d = ST_DONE;
          end
        end
      end

      ST_BUS_SETUP: begin
        latch_d = 1'b1;
        state_d = ST_LATCH;
      end

      ST_LATCH: begin
        // Ack wins over a simultaneous timeout.
        if (RamBusAck) begin
          if (!wrnrd_q) prdata_d = RamBusDataOut;
          ncs_d   = 1'b0;
          latch_d = 1'b0;
          state_d = ST_DONE;
        end else if (timeout_tc) begin
          if (!wrnrd_q) prdata_d = ERR_DATA;
          err_d   = 1'b1;
          ncs_d   = 1'b0;
          latch_d = 1'b0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset returns to IDLE with RamBus idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wrnrd_q  <= 1'b0;
      ncs_q    <= 1'b0;
      latch_q  <= 1'b0;
      prdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wrnrd_q  <= wrnrd_d;
      ncs_q    <= ncs_d;
      latch_q  <= latch_d;
      prdata_q <= prdata_d;
      err_q    <= err_d;
    end
  end

  assign PREADY        = (state_q == ST_DONE);
  assign PSLVERR       = (state_q == ST_DONE) && err_q;
  assign PRDATA        = prdata_q;
  assign RamBusAddress = addr_q;
  assign RamBusDataIn  = wdata_q;
  assign RamBusWrnRd   = wrnrd_q;
  assign RamBusnCs     = ncs_q;
  assign RamBusLatch   = latch_q;

endmodule

// File: tb/tb_apb_rambus_bridge.sv
// Directed bench for apb_rambus_bridge with a RamBus responder model and an
// expected-completion queue. Build with RAMBUS_BRIDGE_TIMEOUT_EN defined to
// exercise the access watchdog (TIMEOUT_CYC = 8).
module tb_apb_rambus_bridge;

  localparam int unsigned    TMO       = 8;
  localparam logic [13:0]    LIMIT     = 14'h0FFF;
  localparam logic [31:0]    ERR_WORD  = 32'hDEADBEEF;
  localparam int             BUDGET    = 100;

  typedef struct {
    logic        is_read;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PSEL, PENABLE, PWRITE;
  logic [13:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [13:0] RamBusAddress;
  logic [31:0] RamBusDataIn;
  logic        RamBusnCs, RamBusWrnRd, RamBusLatch;
  logic [31:0] RamBusDataOut;
  logic        RamBusAck;

  int checks   = 0;
  int failures = 0;

  exp_t sb_q[$];

  // Responder configuration and observations.
  int          ack_dly   = 0;
  logic [31:0] ack_data  = '0;
  logic        ack_stray = 1'b0;
  int          lat_cyc   = 0;
  int          lat_max   = 0;
  int          ncs_rises = 0;
  int          setup_cyc = 0;
  logic        ncs_prev  = 1'b0;
  logic [13:0] cap_addr  = '0;
  logic [31:0] cap_data  = '0;
  logic        cap_wrnrd = 1'b0;
  logic [31:0] last_rdata = '0;

  always #5 clk = ~clk;

  apb_rambus_bridge #(
    .ADDR_LIMIT  (LIMIT),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PWRITE        (PWRITE),
    .PADDR         (PADDR),
    .PWDATA        (PWDATA),
    .PRDATA        (PRDATA),
    .PREADY        (PREADY),
    .PSLVERR       (PSLVERR),
    .RamBusAddress (RamBusAddress),
    .RamBusDataIn  (RamBusDataIn),
    .RamBusnCs     (RamBusnCs),
    .RamBusWrnRd   (RamBusWrnRd),
    .RamBusLatch   (RamBusLatch),
    .RamBusDataOut (RamBusDataOut),
    .RamBusAck     (RamBusAck)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // RamBus device model: acks in the (ack_dly+1)-th LATCH cycle, drives junk
  // on DataOut whenever Ack is low, and records what the bridge presented.
  initial begin
    logic ack_now;
    RamBusAck     = 1'b0;
    RamBusDataOut = '0;
    forever begin
      @(negedge clk);
      if (RamBusLatch) begin
        lat_cyc++;
        if (lat_cyc > lat_max) lat_max = lat_cyc;
        if (lat_cyc == 1) begin
          cap_addr  = RamBusAddress;
          cap_data  = RamBusDataIn;
          cap_wrnrd = RamBusWrnRd;
        end
      end else begin
        lat_cyc = 0;
      end
      if (RamBusnCs && !ncs_prev) ncs_rises++;
      ncs_prev = RamBusnCs;
      if (RamBusnCs && !RamBusLatch) setup_cyc++;
      ack_now       = (RamBusLatch && (lat_cyc == ack_dly + 1)) || ack_stray;
      RamBusAck     = ack_now;
      RamBusDataOut = ack_now ? ack_data : $urandom();
    end
  end

  // Full APB transfer starting at the current negedge; ends one negedge
  // after PREADY with the bus released, ready for a back-to-back transfer.
  task automatic apb_xfer(input logic wr, input logic [13:0] addr, input logic [31:0] wdata,
                          input int dly, input logic [31:0] adata);
    exp_t e, got;
    logic range_err, tmo_hit;
    int   cyc;
    range_err = (addr > LIMIT);
    tmo_hit   = 1'b0;
`ifdef RAMBUS_BRIDGE_TIMEOUT_EN
    tmo_hit = !range_err && (dly + 1 > int'(TMO));
`endif
    e.is_read = !wr;
    e.err     = range_err || tmo_hit;
    e.lat     = range_err ? 1 : (tmo_hit ? 2 + int'(TMO) : 3 + dly);
    e.rdata   = wr ? last_rdata : (e.err ? ERR_WORD : adata);
    last_rdata = e.rdata;
    sb_q.push_back(e);

    ack_dly   = dly;
    ack_data  = adata;
    lat_max   = 0;
    ncs_rises = 0;
    setup_cyc = 0;

    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge clk);
    PENABLE = 1'b1;
    cyc = 1;
    while (!PREADY && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check("pready_seen", 32'(PREADY), 32'd1);
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check("latency", 32'(cyc), 32'(got.lat));
      check("pslverr", 32'(PSLVERR), 32'(got.err));
      check("prdata", PRDATA, got.rdata);
    end
    if (range_err) begin
      check("no_ncs_on_range_err", 32'(ncs_rises), 32'd0);
    end else begin
      check("ncs_pulses", 32'(ncs_rises), 32'd1);
      check("setup_cycles", 32'(setup_cyc), 32'd1);
      check("latch_cycles", 32'(lat_max), tmo_hit ? 32'(TMO) : 32'(dly + 1));
      check("rb_addr", 32'(cap_addr), 32'(addr));
      check("rb_wrnrd", 32'(cap_wrnrd), 32'(wr));
      if (wr) check("rb_wdata", cap_data, wdata);
    end
    @(negedge clk);
    check("pready_single_pulse", 32'(PREADY), 32'd0);
    check("ncs_idle", 32'(RamBusnCs), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pr_cnt;
    int w;
    logic        r_wr;
    logic [13:0] r_addr;
    logic [31:0] r_wd, r_ad;

    rst_n = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_pready", 32'(PREADY), 32'd0);
    check("rst_pslverr", 32'(PSLVERR), 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_rb_ctrl", {29'd0, RamBusnCs, RamBusWrnRd, RamBusLatch}, 32'd0);
    check("rst_rb_addr", 32'(RamBusAddress), 32'd0);
    check("rst_rb_data", RamBusDataIn, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait write, then a read with a 5-cycle Ack delay.
    apb_xfer(1'b1, 14'h0010, 32'h12345678, 0, 32'h0);
    apb_xfer(1'b0, 14'h0020, 32'h0, 5, 32'hCAFEF00D);

    // Out-of-range read and write, then the highest legal address back-to-back.
    apb_xfer(1'b0, 14'h1000, 32'h0, 0, 32'h0);
    apb_xfer(1'b1, 14'h3FFF, 32'hA5A5A5A5, 0, 32'h0);
    apb_xfer(1'b0, 14'h0FFF, 32'h0, 1, 32'h0BADF00D);

    // Back-to-back random in-range traffic.
    for (int i = 0; i < 6; i++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = 14'($urandom_range(0, 32'h0FFF));
      r_wd   = $urandom();
      r_ad   = $urandom();
      apb_xfer(r_wr, r_addr, r_wd, $urandom_range(0, 3), r_ad);
    end

    // Stray Ack while idle must be ignored.
    ack_stray = 1'b1;
    ncs_rises = 0;
    pr_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (PREADY) pr_cnt++;
    end
    ack_stray = 1'b0;
    @(negedge clk);
    check("stray_ack_no_pready", 32'(pr_cnt), 32'd0);
    check("stray_ack_no_ncs", 32'(ncs_rises), 32'd0);
    check("stray_ack_prdata_kept", PRDATA, last_rdata);

    // PSEL dropped after the setup phase: access still completes exactly once.
    ack_dly = 2; ack_data = 32'h0; ncs_rises = 0; pr_cnt = 0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 14'h0100; PWDATA = 32'h55AA55AA;
    @(negedge clk);
    PSEL = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (PREADY) pr_cnt++;
    end
    check("psel_drop_pready_count", 32'(pr_cnt), 32'd1);
    check("psel_drop_ncs_count", 32'(ncs_rises), 32'd1);

    // Reset asserted while in LATCH.
    ack_dly = 1000;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 14'h0040;
    @(negedge clk);
    PENABLE = 1'b1;
    w = 0;
    while (!RamBusLatch && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("reached_latch", 32'(RamBusLatch), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rb_ctrl", {29'd0, RamBusnCs, RamBusWrnRd, RamBusLatch}, 32'd0);
    check("rst_mid_rb_addr", 32'(RamBusAddress), 32'd0);
    check("rst_mid_pready", 32'(PREADY), 32'd0);
    check("rst_mid_prdata", PRDATA, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = '0;
    @(negedge clk);
    apb_xfer(1'b0, 14'h0040, 32'h0, 2, 32'h600DCAFE);

`ifdef RAMBUS_BRIDGE_TIMEOUT_EN
    // No Ack: abort after TMO LATCH cycles, then a normal transfer succeeds.
    apb_xfer(1'b0, 14'h0080, 32'h0, 1000, 32'h0);
    apb_xfer(1'b1, 14'h0081, 32'h13579BDF, 0, 32'h0);
    // Ack in the terminal cycle wins over the timeout.
    apb_xfer(1'b0, 14'h0082, 32'h0, int'(TMO) - 1, 32'hFEEDFACE);
`else
    // Without the watchdog a slow Ack is simply waited for.
    apb_xfer(1'b0, 14'h0080, 32'h0, 20, 32'hFEEDFACE);
`endif

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
